// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: pacing modes,
// FSM state encoding and the trigger qualification helper.
package fetch_pkg;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_CAPT = 2'd3
    } fetch_state_t;

    // Reserved mode 2'b11 falls through to "no trigger", i.e. behaves as halt.
    function automatic logic fetch_trigger(
        input logic [1:0] mode,
        input logic       tick,
        input logic       step_rise
    );
        return ((mode == MODE_RUN) && tick) || ((mode == MODE_STEP) && step_rise);
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Synchronous-read instruction memory port: the fetch unit issues a one-cycle
// read enable with a word address and samples read data MEM_LAT cycles later.
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 32
) ();

    logic              imem_ce;
    logic [ADDR_W-3:0] imem_addr;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_ce,
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_ce,
        input  imem_addr,
        output imem_rdata
    );

endinterface

// File: rtl/inst_fetch_unit_tick_prescaler.sv
// Clock-enable prescaler: one-cycle tick every DIV_MAX enabled cycles.
// Disabling holds the count at zero so re-enabling always starts a full period.
module tick_prescaler #(
    parameter int DIV_W   = 27,
    parameter int DIV_MAX = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV_MAX - 1);

    logic [DIV_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tick = en && (count_reg == LAST);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: owns the PC, sequences one synchronous memory
// read per trigger (free-run tick or step edge) and applies branch/jump redirects.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int               DIV_W    = 27,
    parameter int               DIV_MAX  = 100_000_000,
    parameter int               MEM_LAT  = 1,
    parameter int               CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic                step,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    inst_fetch_unit_if.master   imem,
    output logic [ADDR_W-1:0]   pc,
    output logic [31:0]         inst,
    output logic                inst_valid,
    output logic                busy,
    output logic [CNT_W-1:0]    fetch_count
);

    localparam logic [1:0]        LAT_LOAD   = 2'(MEM_LAT - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(WORD_BYTES);
    localparam bit                HAS_WAIT   = (MEM_LAT > 1);

    fetch_state_t      state_reg;
    logic [1:0]        lat_reg;
    logic [ADDR_W-1:0] fetch_addr_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [31:0]       inst_reg;
    logic              inst_valid_reg;
    logic              ce_reg;
    logic              busy_reg;
    logic [CNT_W-1:0]  fetch_count_reg;
    logic              pend_valid_reg;
    logic [ADDR_W-1:0] pend_pc_reg;
    logic              step_q_reg;

    logic              tick;
    logic              step_rise;
    logic              trigger;
    logic [ADDR_W-1:0] redirect_aligned;
    logic [ADDR_W-1:0] addr_next;

    tick_prescaler #(
        .DIV_W   (DIV_W),
        .DIV_MAX (DIV_MAX)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (mode == MODE_RUN),
        .tick (tick)
    );

    assign step_rise        = step && !step_q_reg;
    assign trigger          = fetch_trigger(mode, tick, step_rise);
    assign redirect_aligned = redirect_pc & ALIGN_MASK;

    // A redirect arriving in the capture cycle itself outranks an older pending one.
    always_comb begin
        addr_next = fetch_addr_reg + ADDR_STEP;
        if (redirect_valid) begin
            addr_next = redirect_aligned;
        end else if (pend_valid_reg) begin
            addr_next = pend_pc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            lat_reg         <= '0;
            fetch_addr_reg  <= RESET_PC;
            pc_reg          <= RESET_PC;
            inst_reg        <= '0;
            inst_valid_reg  <= 1'b0;
            ce_reg          <= 1'b0;
            busy_reg        <= 1'b0;
            fetch_count_reg <= '0;
            pend_valid_reg  <= 1'b0;
            pend_pc_reg     <= '0;
            step_q_reg      <= 1'b0;
        end else begin
            step_q_reg     <= step;
            inst_valid_reg <= 1'b0;
            ce_reg         <= 1'b0;

            if (redirect_valid && (state_reg != S_CAPT)) begin
                pend_valid_reg <= 1'b1;
                pend_pc_reg    <= redirect_aligned;
            end

            case (state_reg)
                S_IDLE: begin
                    if (trigger) begin
                        state_reg <= S_REQ;
                        ce_reg    <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                S_REQ: begin
                    lat_reg   <= LAT_LOAD;
                    state_reg <= HAS_WAIT ? S_WAIT : S_CAPT;
                end
                S_WAIT: begin
                    // Leaving when the count reaches zero keeps WAIT at MEM_LAT-1 cycles.
                    lat_reg <= lat_reg - 2'd1;
                    if (lat_reg == 2'd1) begin
                        state_reg <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    inst_reg        <= imem.imem_rdata;
                    pc_reg          <= fetch_addr_reg;
                    inst_valid_reg  <= 1'b1;
                    fetch_count_reg <= fetch_count_reg + 1'b1;
                    fetch_addr_reg  <= addr_next;
                    pend_valid_reg  <= 1'b0;
                    busy_reg        <= 1'b0;
                    state_reg       <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // fetch_addr only moves in CAPT, so the issued word address stays stable.
    assign imem.imem_ce   = ce_reg;
    assign imem.imem_addr = fetch_addr_reg[ADDR_W-1:2];

    assign pc          = pc_reg;
    assign inst        = inst_reg;
    assign inst_valid  = inst_valid_reg;
    assign busy        = busy_reg;
    assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench: two fetch units (memory latency 1 and 3, prescaler period 4)
// against behavioural memories that return the word index as data.
module tb_inst_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    logic        rst1, rst2;
    logic [1:0]  mode1, mode2;
    logic        step1, step2;
    logic        rv1, rv2;
    logic [31:0] rpc1, rpc2;
    logic [31:0] pc1, pc2, inst1, inst2, fc1, fc2;
    logic        iv1, iv2, busy1, busy2;

    int          pulses1 = 0;
    logic [31:0] last_pc1 = '0;
    logic [31:0] d1_q, d2_q;

    inst_fetch_unit_if #(.ADDR_W(32)) bus1 ();
    inst_fetch_unit_if #(.ADDR_W(32)) bus2 ();

    inst_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .DIV_W(8), .DIV_MAX(4),
                      .MEM_LAT(1), .CNT_W(32)) u1 (
        .clk(clk), .rst(rst1), .mode(mode1), .step(step1),
        .redirect_valid(rv1), .redirect_pc(rpc1), .imem(bus1.master),
        .pc(pc1), .inst(inst1), .inst_valid(iv1), .busy(busy1), .fetch_count(fc1)
    );

    inst_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .DIV_W(8), .DIV_MAX(4),
                      .MEM_LAT(3), .CNT_W(32)) u2 (
        .clk(clk), .rst(rst2), .mode(mode2), .step(step2),
        .redirect_valid(rv2), .redirect_pc(rpc2), .imem(bus2.master),
        .pc(pc2), .inst(inst2), .inst_valid(iv2), .busy(busy2), .fetch_count(fc2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus1.imem_ce) bus1.imem_rdata <= {2'b00, bus1.imem_addr};
    end

    always @(posedge clk) begin
        if (bus2.imem_ce) d1_q <= {2'b00, bus2.imem_addr};
        d2_q            <= d1_q;
        bus2.imem_rdata <= d2_q;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid1(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (iv1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run1(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (iv1) begin
                pulses1++;
                last_pc1 = pc1;
            end
        end
    endtask

    task automatic step1_fetch();
        step1 = 1'b1;
        run1(6);
        step1 = 1'b0;
        run1(2);
    endtask

    initial begin
        bit ok;
        int t_prev;
        int ce_cnt;
        int valid_at;
        int seen;

        rst1 = 1'b1; rst2 = 1'b1;
        mode1 = MODE_HALT; mode2 = MODE_HALT;
        step1 = 1'b0; step2 = 1'b0;
        rv1 = 1'b0; rv2 = 1'b0;
        rpc1 = '0; rpc2 = '0;
        repeat (3) @(negedge clk);

        check("rst_pc", pc1, 32'h0);
        check("rst_inst", inst1, 32'h0);
        check("rst_valid", iv1, 1'b0);
        check("rst_busy", busy1, 1'b0);
        check("rst_ce", bus1.imem_ce, 1'b0);
        check("rst_count", fc1, 32'h0);
        check("rst_busy2", busy2, 1'b0);
        rst1 = 1'b0; rst2 = 1'b0;

        // Free-run, period 4
        mode1 = MODE_RUN;
        wait_valid1(ok); check("run_vld0", ok, 1'b1);
        check("run_pc0", pc1, 32'h0); check("run_inst0", inst1, 32'h0);
        t_prev = cyc;
        wait_valid1(ok); check("run_vld1", ok, 1'b1);
        check("run_pc1", pc1, 32'h4); check("run_inst1", inst1, 32'h1);
        check("run_period1", cyc - t_prev, 4); t_prev = cyc;
        wait_valid1(ok); check("run_vld2", ok, 1'b1);
        check("run_pc2", pc1, 32'h8); check("run_inst2", inst1, 32'h2);
        check("run_period2", cyc - t_prev, 4);
        check("run_count3", fc1, 32'd3);

        // Unaligned redirect in IDLE goes pending and steers the fetch after next
        rv1 = 1'b1; rpc1 = 32'h0000_0103;
        @(negedge clk); rv1 = 1'b0;
        wait_valid1(ok); check("rdir_vld0", ok, 1'b1); check("rdir_pc_seq", pc1, 32'hC);
        wait_valid1(ok); check("rdir_vld1", ok, 1'b1); check("rdir_pc", pc1, 32'h100);
        check("rdir_inst", inst1, 32'h40);

        // Address wrap at the top of the space
        rv1 = 1'b1; rpc1 = 32'hFFFF_FFFC;
        @(negedge clk); rv1 = 1'b0;
        wait_valid1(ok); check("wrap_vld0", ok, 1'b1); check("wrap_pc0", pc1, 32'h104);
        wait_valid1(ok); check("wrap_vld1", ok, 1'b1); check("wrap_pc1", pc1, 32'hFFFF_FFFC);
        check("wrap_inst1", inst1, 32'h3FFF_FFFF);
        wait_valid1(ok); check("wrap_vld2", ok, 1'b1); check("wrap_pc2", pc1, 32'h0);
        check("wrap_inst2", inst1, 32'h0);

        mode1 = MODE_HALT;
        run1(12);
        check("halt_count", fc1, 32'd8);
        check("halt_busy", busy1, 1'b0);

        // Single-step: held button gives one fetch
        rst1 = 1'b1; @(negedge clk); rst1 = 1'b0;
        mode1 = MODE_STEP; pulses1 = 0;
        step1 = 1'b1; run1(20); step1 = 1'b0; run1(4);
        check("step_held_pulses", pulses1, 1);
        check("step_held_pc", last_pc1, 32'h0);
        step1_fetch();
        check("step2_pulses", pulses1, 2);
        check("step2_pc", last_pc1, 32'h4);
        check("step2_count", fc1, 32'd2);
        mode1 = MODE_HALT;
        step1_fetch();
        check("step_halt_pulses", pulses1, 2);
        mode1 = MODE_STEP;

        // Redirect in REQ goes pending; redirect in CAPT overrides it
        step1 = 1'b1;
        @(negedge clk);
        check("capt_req_ce", bus1.imem_ce, 1'b1);
        check("capt_req_busy", busy1, 1'b1);
        rv1 = 1'b1; rpc1 = 32'h80;
        @(negedge clk);
        rpc1 = 32'h40;
        @(negedge clk);
        rv1 = 1'b0;
        check("capt_vld", iv1, 1'b1);
        check("capt_pc", pc1, 32'h8);
        step1 = 1'b0; run1(2);
        step1_fetch();
        check("capt_next_pc", last_pc1, 32'h40);

        // Two redirects before a capture: last one wins
        rv1 = 1'b1; rpc1 = 32'h200;
        @(negedge clk); rpc1 = 32'h300;
        @(negedge clk); rv1 = 1'b0;
        step1_fetch();
        check("two_rdir_seq_pc", last_pc1, 32'h44);
        step1_fetch();
        check("two_rdir_pc", last_pc1, 32'h300);
        check("two_rdir_inst", inst1, 32'hC0);

        // MEM_LAT=3: latency, single ce cycle, step while busy dropped
        mode2 = MODE_STEP;
        @(negedge clk);
        step2 = 1'b1;
        ce_cnt = 0; valid_at = -1;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (bus2.imem_ce) ce_cnt++;
            if (iv2) valid_at = n;
            if (n == 2) step2 = 1'b0;
            if (n == 3) step2 = 1'b1;
        end
        check("lat3_ce_cycles", ce_cnt, 1);
        check("lat3_valid_at", valid_at, 5);
        check("lat3_count", fc2, 32'd1);
        check("lat3_pc", pc2, 32'h0);
        check("lat3_inst", inst2, 32'h0);

        step2 = 1'b0; repeat (2) @(negedge clk);
        step2 = 1'b1; repeat (7) @(negedge clk); step2 = 1'b0;
        check("lat3_pc2", pc2, 32'h4);
        check("lat3_count2", fc2, 32'd2);
        repeat (2) @(negedge clk);

        // Reset while waiting on memory aborts the fetch
        step2 = 1'b1;
        @(negedge clk);
        check("wrst_busy_req", busy2, 1'b1);
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        check("wrst_pc", pc2, 32'h0);
        check("wrst_busy", busy2, 1'b0);
        check("wrst_valid", iv2, 1'b0);
        check("wrst_count", fc2, 32'd0);
        check("wrst_ce", bus2.imem_ce, 1'b0);
        rst2 = 1'b0; step2 = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (iv2) seen++;
        end
        check("wrst_no_capture", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
